// File: rtl/dds_cfg_axis_tx_if.sv
// AXI4-Stream bundle carrying DDS configuration words from the transmitter
// to the signal-generator configuration port.
interface dds_cfg_axis_tx_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/dds_cfg_axis_tx.sv
// Modulated-DDS configuration packet transmitter.
// A register port fills an NDDS x 11 parameter table; a start request then
// streams 12-word packets (ADDR, WAIT, FMOD_C0..C5, FMOD_G, AMOD_C0/C1, POFF)
// for a run of consecutive entries, wrapping modulo NDDS. Each packet is
// streamed from a shadow snapshot taken in LOAD, so later table writes only
// affect later packets.
module dds_cfg_axis_tx #(
    parameter  int NDDS  = 16,
    parameter  int BFREQ = 32,
    parameter  int BAMP  = 16,
    parameter  int GAP   = 4,
    localparam int BA    = $clog2(NDDS)
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   cfg_we,
    input  logic [BA-1:0]          cfg_addr,
    input  logic [3:0]             cfg_word,
    input  logic [31:0]            cfg_wdata,
    input  logic                   start,
    input  logic [BA-1:0]          first,
    input  logic [BA:0]            count,
    output logic                   busy,
    output logic                   done,
    dds_cfg_axis_tx_if.master      m_axis
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [31:0] GAP_LAST = (GAP > 0) ? 32'(GAP - 1) : 32'd0;
    localparam logic [BA:0] REM_ONE  = {{BA{1'b0}}, 1'b1};
    localparam logic [BA:0] REM_ZERO = {(BA+1){1'b0}};

    // Mask selecting the low 'bits' bits of a word (all ones for 32 or more).
    function automatic logic [31:0] low_mask(input int unsigned bits);
        if (bits >= 32) low_mask = 32'hFFFF_FFFF;
        else            low_mask = (32'd1 << bits) - 32'd1;
    endfunction

    // Sign-extend the low 'bits' bits of v to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned bits);
        logic [31:0] m;
        m = low_mask(bits);
        if (bits >= 32)        sext = v;
        else if (v[bits-1])    sext = v | ~m;
        else                   sext = v & m;
    endfunction

    // Format a table word for transmission according to its position in the packet.
    function automatic logic [31:0] fmt_word(input logic [3:0] k, input logic [31:0] raw);
        case (k)
            4'd1:                          fmt_word = raw & low_mask(BFREQ);
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
            4'd7, 4'd8, 4'd11:             fmt_word = sext(raw, BFREQ);
            4'd9, 4'd10:                   fmt_word = sext(raw, BAMP);
            default:                       fmt_word = 32'd0;
        endcase
    endfunction

    logic [31:0] table_r  [0:NDDS-1][0:10];
    logic [31:0] shadow_r [0:10];

    state_t        state_r, state_n;
    logic [BA-1:0] ptr_r, ptr_n;
    logic [BA:0]   rem_r, rem_n;
    logic [3:0]    idx_r, idx_n;
    logic [31:0]   gap_cnt_r, gap_cnt_n;
    logic          tvalid_r, tvalid_n;
    logic [31:0]   tdata_r, tdata_n;
    logic          tlast_r, tlast_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;

    // Parameter table write port; contents survive reset, bad word indices are dropped.
    always_ff @(posedge m_axis_aclk) begin
        if (cfg_we && (cfg_word >= 4'd1) && (cfg_word <= 4'd11)) begin
            table_r[cfg_addr][cfg_word - 4'd1] <= cfg_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) state_r <= ST_IDLE;
        else                 state_r <= state_n;
    end

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        rem_n     = rem_r;
        idx_n     = idx_r;
        gap_cnt_n = gap_cnt_r;
        tvalid_n  = tvalid_r;
        tdata_n   = tdata_r;
        tlast_n   = tlast_r;
        busy_n    = busy_r;
        done_n    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    ptr_n  = first;
                    rem_n  = count;
                    busy_n = 1'b1;
                    if (count == REM_ZERO) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_n    = 4'd0;
                tvalid_n = 1'b1;
                tdata_n  = 32'(ptr_r);
                tlast_n  = 1'b0;
                state_n  = ST_SEND;
            end
            ST_SEND: begin
                if (tvalid_r && m_axis.tready) begin
                    if (idx_r == 4'd11) begin
                        ptr_n     = ptr_r + {{(BA-1){1'b0}}, 1'b1};
                        rem_n     = rem_r - REM_ONE;
                        tvalid_n  = 1'b0;
                        tlast_n   = 1'b0;
                        gap_cnt_n = 32'd0;
                        if (rem_r == REM_ONE) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else if (GAP == 0) begin
                            state_n = ST_LOAD;
                        end else begin
                            state_n = ST_GAP;
                        end
                    end else begin
                        idx_n   = idx_r + 4'd1;
                        tdata_n = fmt_word(idx_r + 4'd1, shadow_r[idx_r]);
                        tlast_n = (idx_r == 4'd10) && (rem_r == REM_ONE);
                    end
                end else begin
                    state_n = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_n = 32'd0;
                    state_n   = ST_LOAD;
                end else begin
                    gap_cnt_n = gap_cnt_r + 32'd1;
                end
            end
            ST_DONE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n  = ST_IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                busy_n   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; the shadow snapshot is taken in LOAD.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            ptr_r     <= '0;
            rem_r     <= '0;
            idx_r     <= 4'd0;
            gap_cnt_r <= 32'd0;
            tvalid_r  <= 1'b0;
            tdata_r   <= 32'd0;
            tlast_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < 11; i++) shadow_r[i] <= 32'd0;
        end else begin
            ptr_r     <= ptr_n;
            rem_r     <= rem_n;
            idx_r     <= idx_n;
            gap_cnt_r <= gap_cnt_n;
            tvalid_r  <= tvalid_n;
            tdata_r   <= tdata_n;
            tlast_r   <= tlast_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            if (state_r == ST_LOAD) shadow_r <= table_r[ptr_r];
        end
    end

    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;
    assign m_axis.tlast  = tlast_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_dds_cfg_axis_tx.sv
// Directed bench for dds_cfg_axis_tx: single packet, back-pressure, wrapping
// multi-packet burst, empty burst, shadow snapshot and mid-burst reset.
module tb_dds_cfg_axis_tx;

    localparam int NDDS = 16;
    localparam int GAP  = 4;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_word;
    logic [31:0] cfg_wdata;
    logic        start;
    logic [3:0]  first;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    dds_cfg_axis_tx_if axis_if();

    dds_cfg_axis_tx #(.NDDS(NDDS), .BFREQ(32), .BAMP(16), .GAP(GAP)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_word       (cfg_word),
        .cfg_wdata      (cfg_wdata),
        .start          (start),
        .first          (first),
        .count          (count),
        .busy           (busy),
        .done           (done),
        .m_axis         (axis_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp1 [0:11] = '{32'd0, 32'd0, 32'd655, 32'd4211, 32'd11850, 32'hFFFFCD09,
                                 32'hFFFF9DCD, 32'd25139, 32'd8110, 32'd32440, 32'hFFFFC148, 32'd0};
    logic [31:0] tbl1 [1:11] = '{32'd0, 32'd655, 32'd4211, 32'd11850, 32'hFFFFCD09, 32'hFFFF9DCD,
                                 32'd25139, 32'd8110, 32'd32440, 32'h0000C148, 32'd0};

    logic [31:0] got_d   [0:63];
    logic        got_l   [0:63];
    int          got_cyc [0:63];
    int          got_n;
    int          idle_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_word = w; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_burst(input logic [3:0] f, input logic [4:0] c);
        first = f; count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Collect nbeats handshakes; optionally write entry0 FMOD_C0 (plus a stray
    // start) when beat wr_beat is presented, or reset when beat rst_beat is presented.
    task automatic recv(input int nbeats, input bit rnd, input int wr_beat, input int rst_beat);
        bit          stall;
        logic [31:0] pd;
        logic        pl;
        int          cyc;
        got_n = 0; idle_n = 0; stall = 1'b0; cyc = 0; pd = 32'd0; pl = 1'b0;
        while (got_n < nbeats && cyc < 2000) begin
            axis_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stall) begin
                chk("stall_tvalid", 32'(axis_if.tvalid), 32'd1);
                chk("stall_tdata", axis_if.tdata, pd);
                chk("stall_tlast", 32'(axis_if.tlast), 32'(pl));
            end
            if (axis_if.tvalid && axis_if.tready) begin
                got_d[got_n] = axis_if.tdata;
                got_l[got_n] = axis_if.tlast;
                got_cyc[got_n] = cyc;
                got_n++;
                stall = 1'b0;
                if (got_n == wr_beat) begin
                    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_word = 4'd2; cfg_wdata = 32'd327;
                    start = 1'b1; first = 4'd3; count = 5'd5;
                end
                if (got_n == rst_beat) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                end
            end else begin
                stall = axis_if.tvalid;
                pd = axis_if.tdata;
                pl = axis_if.tlast;
                if (!axis_if.tvalid && got_n > 0) idle_n++;
            end
            tick();
            cfg_we = 1'b0;
            start = 1'b0;
            cyc++;
        end
        chk("beat_count", 32'(got_n), 32'(nbeats));
    endtask

    task automatic chk_pkt(input string tag, input int base);
        for (int i = 0; i < 12; i++) chk($sformatf("%s_beat%0d", tag, i), got_d[base + i], exp1[i]);
    endtask

    task automatic chk_last(input string tag, input int n);
        for (int i = 0; i < n; i++) chk($sformatf("%s_tlast%0d", tag, i), 32'(got_l[i]), 32'(i == n - 1));
    endtask

    // Start a one-entry burst of entry 0 and check timing around it.
    task automatic t1_burst(input string tag, input bit rnd);
        start_burst(4'd0, 5'd1);
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_tvalid_lat1"}, 32'(axis_if.tvalid), 32'd0);
        tick();
        chk({tag, "_tvalid_lat2"}, 32'(axis_if.tvalid), 32'd1);
        recv(12, rnd, -1, -1);
        chk_pkt(tag, 0);
        chk_last(tag, 12);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_word = 4'd0; cfg_wdata = 32'd0;
        start = 1'b0; first = 4'd0; count = 5'd0; axis_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("reset_tlast", 32'(axis_if.tlast), 32'd0);
        chk("reset_tdata", axis_if.tdata, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: entry 0 table contents, then out-of-range word writes that must be dropped.
        for (int w = 1; w <= 11; w++) wr(4'd0, 4'(w), tbl1[w]);
        wr(4'd0, 4'd0, 32'hDEAD_BEEF);
        wr(4'd0, 4'd12, 32'hDEAD_BEEF);
        wr(4'd0, 4'd15, 32'hDEAD_BEEF);
        t1_burst("t1", 1'b0);

        // T2: same packet under random back-pressure.
        t1_burst("t2", 1'b1);

        // T3: wrapping 4-packet burst starting at entry 14.
        start_burst(4'd14, 5'd4);
        tick();
        recv(48, 1'b0, -1, -1);
        chk("t3_addr0", got_d[0], 32'd14);
        chk("t3_addr1", got_d[12], 32'd15);
        chk("t3_addr2", got_d[24], 32'd0);
        chk("t3_addr3", got_d[36], 32'd1);
        chk_pkt("t3_entry0", 24);
        chk_last("t3", 48);
        chk("t3_gap01", 32'(got_cyc[12] - got_cyc[11]), 32'(GAP + 2));
        chk("t3_gap23", 32'(got_cyc[36] - got_cyc[35]), 32'(GAP + 2));
        chk("t3_idle_total", 32'(idle_n), 32'(3 * (GAP + 1)));
        chk("t3_done", 32'(done), 32'd1);
        tick();

        // T4: empty burst.
        start_burst(4'd5, 5'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_tvalid0", 32'(axis_if.tvalid), 32'd0);
        tick();
        chk("t4_done_clear", 32'(done), 32'd0);
        chk("t4_busy_clear", 32'(busy), 32'd0);
        chk("t4_tvalid1", 32'(axis_if.tvalid), 32'd0);
        tick();
        chk("t4_tvalid2", 32'(axis_if.tvalid), 32'd0);

        // T5: rewrite entry 0 FMOD_C0 during beat 5, with a stray start.
        start_burst(4'd0, 5'd1);
        tick();
        recv(12, 1'b0, 5, -1);
        chk_pkt("t5_old", 0);
        chk("t5_done", 32'(done), 32'd1);
        tick();
        tick();
        chk("t5_stray_busy", 32'(busy), 32'd0);
        chk("t5_stray_tvalid", 32'(axis_if.tvalid), 32'd0);
        start_burst(4'd0, 5'd1);
        tick();
        recv(12, 1'b0, -1, -1);
        chk("t5_new_fmod_c0", got_d[2], 32'd327);
        chk("t5_new_fmod_c1", got_d[3], 32'd4211);
        tick();
        wr(4'd0, 4'd2, 32'd655);

        // T6: reset at beat 6 of packet 2, then a clean burst.
        start_burst(4'd0, 5'd2);
        tick();
        recv(18, 1'b0, -1, 18);
        chk("t6_hold_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("t6_hold_tdata", axis_if.tdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        t1_burst("t6", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
